alu_operand_regfile: RTL and testbench

- Upstream neighbour of the 8-bit ALU in the single-cycle datapath.
- Holds the general-purpose register file that drives ALU inputs A and B.
- Holds the carry/zero flag register. Its carry output feeds ALU carry_in, and it latches ALU carry_out/zero on flag-setting instructions.
- Provides a one-deep flag shadow so call/return sequences can save and restore C/Z.

---
 rtl/alu_operand_regfile.sv | 124 ++++++++++++
 tb/tb_alu_operand_regfile.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_operand_regfile.sv
// alu_operand_regfile: general-purpose register file and C/Z flag register
// feeding the 8-bit ALU, with a one-deep flag shadow for call/return.
//
// Register 0 reads as zero and ignores writes. Reads are combinational;
// flags and the shadow are purely registered.
//
// Build option: define REGFILE_WRITE_BYPASS_EN to forward wr_data to a read
// port whose address matches an active write in the same cycle. Without it,
// a written value becomes readable in the following cycle.
module alu_operand_regfile #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flag_we,
   input  logic              alu_carry,
   input  logic              alu_zero,
   input  logic              flag_save,
   input  logic              flag_restore,
   output logic              carry_flag,
   output logic              zero_flag
);

   logic [DATA_W-1:0] regs_r [NUM_REGS];
   logic              wr_hit_s;
   logic              shadow_c_r;
   logic              shadow_z_r;
   logic              carry_nxt_s;
   logic              zero_nxt_s;
   logic              shadow_c_nxt_s;
   logic              shadow_z_nxt_s;

   assign wr_hit_s = wr_en && (wr_addr != {ADDR_W{1'b0}});

   // Register storage: cleared on reset, written when a non-zero address is targeted.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_hit_s) begin
         regs_r[wr_addr] <= wr_data;
      end
   end

   // Read port A: r0 is constant zero, optional same-cycle forwarding of the write.
   always_comb begin
      rd_data_a = {DATA_W{1'b0}};
      if (rd_addr_a == {ADDR_W{1'b0}}) begin
         rd_data_a = {DATA_W{1'b0}};
`ifdef REGFILE_WRITE_BYPASS_EN
      end else if (wr_hit_s && (wr_addr == rd_addr_a)) begin
         rd_data_a = wr_data;
`endif
      end else begin
         rd_data_a = regs_r[rd_addr_a];
      end
   end

   // Read port B: same behaviour as port A.
   always_comb begin
      rd_data_b = {DATA_W{1'b0}};
      if (rd_addr_b == {ADDR_W{1'b0}}) begin
         rd_data_b = {DATA_W{1'b0}};
`ifdef REGFILE_WRITE_BYPASS_EN
      end else if (wr_hit_s && (wr_addr == rd_addr_b)) begin
         rd_data_b = wr_data;
`endif
      end else begin
         rd_data_b = regs_r[rd_addr_b];
      end
   end

   // Flag next-state: restore beats ALU latch; the shadow always captures pre-edge flags,
   // so save+restore together swaps flags and shadow.
   always_comb begin
      carry_nxt_s    = carry_flag;
      zero_nxt_s     = zero_flag;
      shadow_c_nxt_s = shadow_c_r;
      shadow_z_nxt_s = shadow_z_r;
      if (flag_restore) begin
         carry_nxt_s = shadow_c_r;
         zero_nxt_s  = shadow_z_r;
      end else if (flag_we) begin
         carry_nxt_s = alu_carry;
         zero_nxt_s  = alu_zero;
      end else begin
         carry_nxt_s = carry_flag;
         zero_nxt_s  = zero_flag;
      end
      if (flag_save) begin
         shadow_c_nxt_s = carry_flag;
         shadow_z_nxt_s = zero_flag;
      end else begin
         shadow_c_nxt_s = shadow_c_r;
         shadow_z_nxt_s = shadow_z_r;
      end
   end

   // Flag and shadow registers; reset clears everything and discards a pending save.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
         shadow_c_r <= 1'b0;
         shadow_z_r <= 1'b0;
      end else begin
         carry_flag <= carry_nxt_s;
         zero_flag  <= zero_nxt_s;
         shadow_c_r <= shadow_c_nxt_s;
         shadow_z_r <= shadow_z_nxt_s;
      end
   end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Scoreboard bench for alu_operand_regfile: a behavioural model computes the
// expected read data and flags when each cycle's stimulus is driven; the
// values are queued and compared when the DUT presents its outputs.
module tb_alu_operand_regfile;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] rd_addr_a, rd_addr_b, wr_addr;
   logic [7:0] rd_data_a, rd_data_b, wr_data;
   logic       wr_en, flag_we, alu_carry, alu_zero, flag_save, flag_restore;
   logic       carry_flag, zero_flag;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } sb_t;
   sb_t sb[$];

   // Reference model state
   logic [7:0] m_regs [8];
   logic       m_c, m_z, m_sc, m_sz;

   alu_operand_regfile dut (
      .clk(clk), .rst(rst),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .flag_we(flag_we), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .flag_save(flag_save), .flag_restore(flag_restore),
      .carry_flag(carry_flag), .zero_flag(zero_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [2:0] a);
      if (a == 3'd0) return 8'h00;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_en && wr_addr != 3'd0 && wr_addr == a) return wr_data;
`endif
      return m_regs[a];
   endfunction

   task automatic pop_check(input string what, input logic [15:0] got);
      sb_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s scoreboard empty got=%h", what, got);
      end else begin
         e = sb.pop_front();
         check(e.tag, got, e.exp);
      end
   endtask

   // One clock cycle: drive, queue expectations, compare reads mid-cycle, flags after the edge.
   task automatic cyc(input string tag, input logic [2:0] ra, input logic [2:0] rb,
                      input logic we, input logic [2:0] wa, input logic [7:0] wd,
                      input logic fwe, input logic ac, input logic az,
                      input logic fs, input logic fr, input logic rs);
      logic oc, oz;
      rd_addr_a = ra; rd_addr_b = rb;
      wr_en = we; wr_addr = wa; wr_data = wd;
      flag_we = fwe; alu_carry = ac; alu_zero = az;
      flag_save = fs; flag_restore = fr; rst = rs;
      sb.push_back('{{tag, "_rda"}, {8'h00, m_read(ra)}});
      sb.push_back('{{tag, "_rdb"}, {8'h00, m_read(rb)}});
      #4;
      pop_check("rda", {8'h00, rd_data_a});
      pop_check("rdb", {8'h00, rd_data_b});
      oc = m_c; oz = m_z;
      if (rs) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
         m_c = 1'b0; m_z = 1'b0; m_sc = 1'b0; m_sz = 1'b0;
      end else begin
         if (we && wa != 3'd0) m_regs[wa] = wd;
         if (fr) begin
            m_c = m_sc; m_z = m_sz;
         end else if (fwe) begin
            m_c = ac; m_z = az;
         end
         if (fs) begin
            m_sc = oc; m_sz = oz;
         end
      end
      sb.push_back('{{tag, "_flags"}, {14'h0, m_c, m_z}});
      @(posedge clk);
      #1;
      pop_check("flags", {14'h0, carry_flag, zero_flag});
   endtask

   initial begin
      rd_addr_a = 3'd0; rd_addr_b = 3'd0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
      flag_we = 1'b0; alu_carry = 1'b0; alu_zero = 1'b0;
      flag_save = 1'b0; flag_restore = 1'b0; rst = 1'b1;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_c = 1'b0; m_z = 1'b0; m_sc = 1'b0; m_sz = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_flags", {14'h0, carry_flag, zero_flag}, 16'h0000);

      // Reset clears registers, flags and shadow
      //     tag        ra    rb    we    wa    wd     fwe   ac    az    fs    fr    rs
      cyc("rst_w",    3'd0, 3'd0, 1'b1, 3'd3, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rst_pre_c_z", {14'h0, carry_flag, zero_flag}, 16'h0003);
      cyc("rst_sv",   3'd3, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("rst_do",   3'd3, 3'd0, 1'b1, 3'd3, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc("rst_rd",   3'd3, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_r3", {8'h00, rd_data_a}, 16'h0000);
      cyc("rst_rest", 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("rst_restore", {14'h0, carry_flag, zero_flag}, 16'h0000);

      // r0 protection
      cyc("r0_w",     3'd0, 3'd0, 1'b1, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("r0_rd",    3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("r0_ab", {rd_data_a, rd_data_b}, 16'h0000);

      // Write/read timing on r5
      cyc("wr5",      3'd5, 3'd5, 1'b1, 3'd5, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("rd5",      3'd5, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rd5_next", {8'h00, rd_data_a}, 16'h0081);

      // Flag latch gating
      cyc("fl_we",    3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("fl_hold",  3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("fl_hold_cz", {14'h0, carry_flag, zero_flag}, 16'h0002);

      // Save / clobber / restore
      cyc("sr_set",   3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("sr_save",  3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("sr_clob",  3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("sr_rest",  3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("sr_restored", {14'h0, carry_flag, zero_flag}, 16'h0003);

      // Simultaneous events: shadow=0/1, flags=1/0, then swap, then restore+we
      cyc("sim_z",    3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("sim_sv",   3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("sim_c",    3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("sim_swap", 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("swap_cz", {14'h0, carry_flag, zero_flag}, 16'h0001);
      cyc("sim_rw",   3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("rest_wins", {14'h0, carry_flag, zero_flag}, 16'h0002);
      cyc("sim_svwe", 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("sim_chk",  3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("save_we", {14'h0, carry_flag, zero_flag}, 16'h0002);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         cyc("rnd", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 31) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
